ins_fetch_queue: RTL and testbench

//  Pipelined instruction-fetch unit between the PC stage and decode. It keeps up to
//  MAX_OUTSTANDING granted reads in flight on the instruction-memory req/gnt/rvalid bus.

---
 rtl/ifetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 87 ++++++++
 rtl/ins_fetch_queue_chk.sv | 34 +++
 rtl/ins_fetch_queue.sv | 208 ++++++++++++++++++++
 tb/tb_ins_fetch_queue.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants and helpers for the instruction-fetch queue.
package ifetch_pkg;

    // Canonical RISC-V NOP (addi x0, x0, 0), shown on the decode port when idle.
    localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

    // Fetch control states.
    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    // Number of bits needed to hold values 0..n-1 (ceil(log2(n))).
    function automatic int unsigned clog2_f(input int unsigned n);
        int unsigned r;
        r = 32'd0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 32'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with circular pointers, occupancy count and a
// synchronous clear. Used for both the PC-tag FIFO and the instruction queue.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = clog2_f(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? clog2_f(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Qualify push/pop; a full FIFO still accepts a push when it pops in the same cycle.
    always_comb begin
        do_pop_s  = pop & (count_r != {CNT_W{1'b0}});
        do_push_s = push & ((count_r != CNT_W'(DEPTH)) | do_pop_s);
        empty     = (count_r == {CNT_W{1'b0}});
        full      = (count_r == CNT_W'(DEPTH));
        count     = count_r;
        rdata     = mem_r[rd_ptr_r];
    end

    // Entry storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s && !clear) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; clear empties the FIFO and wins over push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ins_fetch_queue_chk.sv
// Protocol and credit invariants of the fetch queue, kept apart from the datapath.
module ins_fetch_queue_chk (
    input logic clk,
    input logic reset_n,
    input logic q_push,
    input logic q_pop,
    input logic q_full,
    input logic gnt,
    input logic tag_full,
    input logic rsp,
    input logic tag_empty,
    input logic tag_count_ok,
    input logic stray_rvalid
);

    // The credit rule must always leave a free queue slot for a returning word.
    a_no_queue_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(q_push && q_full && !q_pop));

    // A grant never exceeds the in-flight limit.
    a_no_tag_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(gnt && tag_full && !rsp));

    // Counted responses always have a tag to pop.
    a_no_tag_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(rsp && tag_empty));

    // Tag FIFO occupancy tracks the outstanding counter.
    a_tag_count: assert property (@(posedge clk) disable iff (!reset_n) tag_count_ok);

    // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
    c_stray_rvalid: cover property (@(posedge clk) disable iff (!reset_n) stray_rvalid);

endmodule

// File: rtl/ins_fetch_queue.sv
// Pipelined instruction fetch: issues reads on a req/gnt/rvalid bus with a
// bounded number in flight, tags returned words with their PC, queues them for
// decode, and discards in-flight responses after a flush.
module ins_fetch_queue
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W          = 32,
    parameter int                DATA_W          = 32,
    parameter int                MAX_OUTSTANDING = 2,
    parameter int                FIFO_DEPTH      = 4,
    parameter logic [DATA_W-1:0] NOP_INSTR       = DATA_W'(NOP_INSTR_C)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_i_valid,
    output logic              pc_ready_o,
    input  logic              flush_i,
    input  logic              stop_request_overide,
    output logic [DATA_W-1:0] instruction_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              instr_valid_o,
    input  logic              stall_i_EXEC,
    output logic              reset_able,
    output logic              data_clk,
    output logic              data_req_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_gnt_i,
    input  logic              data_rvalid_i,
    input  logic [DATA_W-1:0] data_rdata_i
);

    localparam int OUT_W = clog2_f(MAX_OUTSTANDING + 1);
    localparam int Q_W   = clog2_f(FIFO_DEPTH + 1);

    logic [0:0]               state_r;
    logic [0:0]               state_nxt_s;
    logic [OUT_W-1:0]         outstanding_r;
    logic [OUT_W-1:0]         outstanding_nxt_s;
    logic [OUT_W-1:0]         discard_r;
    logic [OUT_W-1:0]         discard_nxt_s;
    logic [31:0]              inflight_s;
    logic                     issue_ok_s;
    logic                     drain_done_s;
    logic                     req_s;
    logic                     gnt_s;
    logic                     rsp_s;
    logic                     drop_s;
    logic                     q_push_s;
    logic                     q_pop_s;
    logic                     q_empty_s;
    logic                     q_full_s;
    logic [Q_W-1:0]           q_count_s;
    logic [ADDR_W+DATA_W-1:0] q_rdata_s;
    logic [ADDR_W-1:0]        tag_s;
    logic                     tag_empty_s;
    logic                     tag_full_s;
    logic [OUT_W-1:0]         tag_count_s;
    logic                     stray_rvalid_s;

    // Issue, response and credit decisions for the current cycle.
    always_comb begin
        // Responses only count while something is outstanding.
        rsp_s          = data_rvalid_i & (outstanding_r != {OUT_W{1'b0}});
        stray_rvalid_s = data_rvalid_i & (outstanding_r == {OUT_W{1'b0}});
        drop_s         = rsp_s & (discard_r != {OUT_W{1'b0}});
        // Drain ends in the cycle the last discarded word arrives; issue may resume then.
        drain_done_s   = (state_r == S_DRAIN) & drop_s & (discard_r == OUT_W'(1));
        inflight_s     = 32'(outstanding_r) + 32'(q_count_s);
        issue_ok_s     = ((state_r == S_RUN) | drain_done_s)
                       & (inflight_s < 32'(FIFO_DEPTH))
                       & (32'(outstanding_r) < 32'(MAX_OUTSTANDING));
        req_s          = reset_n & pc_i_valid & ~flush_i & ~stop_request_overide & issue_ok_s;
        gnt_s          = req_s & data_gnt_i;
        q_push_s       = rsp_s & ~drop_s & ~flush_i;
        q_pop_s        = ~q_empty_s & ~stall_i_EXEC;
    end

    // Next-state for the outstanding/discard counters and the drain FSM.
    always_comb begin
        outstanding_nxt_s = outstanding_r;
        discard_nxt_s     = discard_r;
        state_nxt_s       = state_r;
        if (gnt_s && !rsp_s) begin
            outstanding_nxt_s = outstanding_r + OUT_W'(1);
        end else if (rsp_s && !gnt_s) begin
            outstanding_nxt_s = outstanding_r - OUT_W'(1);
        end else begin
            outstanding_nxt_s = outstanding_r;
        end
        // After a flush every read still in flight is stale; in drain these are
        // already marked, so the total simply tracks what remains outstanding.
        if (flush_i) begin
            discard_nxt_s = outstanding_r - (rsp_s ? OUT_W'(1) : OUT_W'(0));
        end else if (drop_s) begin
            discard_nxt_s = discard_r - OUT_W'(1);
        end else begin
            discard_nxt_s = discard_r;
        end
        case (state_r)
            S_RUN: begin
                if (flush_i && (discard_nxt_s != {OUT_W{1'b0}})) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_DRAIN: begin
                if (discard_nxt_s == {OUT_W{1'b0}}) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            default: state_nxt_s = S_RUN;
        endcase
    end

    // Counter and state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= S_RUN;
            outstanding_r <= {OUT_W{1'b0}};
            discard_r     <= {OUT_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            discard_r     <= discard_nxt_s;
        end
    end

    // PC tags of granted reads, popped in grant order as responses return.
    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (1'b0),
        .push    (gnt_s),
        .wdata   (pc_i),
        .pop     (rsp_s),
        .rdata   (tag_s),
        .empty   (tag_empty_s),
        .full    (tag_full_s),
        .count   (tag_count_s)
    );

    // Instruction queue of {pc, word}; its head is decode's view.
    fetch_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (flush_i),
        .push    (q_push_s),
        .wdata   ({tag_s, data_rdata_i}),
        .pop     (q_pop_s),
        .rdata   (q_rdata_s),
        .empty   (q_empty_s),
        .full    (q_full_s),
        .count   (q_count_s)
    );

    // Decode-side and memory-side output drive.
    always_comb begin
        pc_ready_o   = gnt_s;
        data_req_o   = req_s;
        data_clk     = clk;
        data_we_o    = 1'b0;
        data_be_o    = 4'b1111;
        data_wdata_o = {DATA_W{1'b0}};
        reset_able   = (outstanding_r == {OUT_W{1'b0}}) & (discard_r == {OUT_W{1'b0}}) & ~req_s;
        if (req_s) begin
            data_addr_o = pc_i;
        end else begin
            data_addr_o = {ADDR_W{1'b0}};
        end
        if (q_empty_s) begin
            instr_valid_o = 1'b0;
            instruction_o = NOP_INSTR;
            instr_pc_o    = {ADDR_W{1'b0}};
        end else begin
            instr_valid_o = 1'b1;
            instruction_o = q_rdata_s[DATA_W-1:0];
            instr_pc_o    = q_rdata_s[ADDR_W+DATA_W-1:DATA_W];
        end
    end

    ins_fetch_queue_chk u_chk (
        .clk          (clk),
        .reset_n      (reset_n),
        .q_push       (q_push_s),
        .q_pop        (q_pop_s),
        .q_full       (q_full_s),
        .gnt          (gnt_s),
        .tag_full     (tag_full_s),
        .rsp          (rsp_s),
        .tag_empty    (tag_empty_s),
        .tag_count_ok (tag_count_s == outstanding_r),
        .stray_rvalid (stray_rvalid_s)
    );

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Scenario bench for ins_fetch_queue: a memory model answers grants in order,
// a scoreboard holds expected {pc, word} pairs pushed at grant time and popped
// when decode consumes a word.
`timescale 1ns/1ps
module tb_ins_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc_i = 32'd0;
    logic        pc_i_valid = 1'b0;
    logic        pc_ready_o;
    logic        flush_i = 1'b0;
    logic        stop_request_overide = 1'b0;
    logic [31:0] instruction_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        stall_i_EXEC = 1'b0;
    logic        reset_able;
    logic        data_clk;
    logic        data_req_o;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i = 1'b0;
    logic        data_rvalid_i = 1'b0;
    logic [31:0] data_rdata_i = 32'd0;

    always #5 clk = ~clk;

    ins_fetch_queue #(
        .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2), .FIFO_DEPTH(4), .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pc_i(pc_i), .pc_i_valid(pc_i_valid),
        .pc_ready_o(pc_ready_o), .flush_i(flush_i), .stop_request_overide(stop_request_overide),
        .instruction_o(instruction_o), .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o),
        .stall_i_EXEC(stall_i_EXEC), .reset_able(reset_able), .data_clk(data_clk),
        .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [31:0] rsp_addr_q[$];
    int          rsp_due_q[$];
    logic [63:0] exp_q[$];

    logic [31:0] next_pc;
    logic        stall_v, flush_v;
    int grant_limit, grants, gnt_delay, req_age, rsp_lat, pops;
    int first_grant_cyc, first_valid_cyc, last_pop_cyc, ready_cnt, req_cnt;
    logic [31:0] last_pop_pc;

    task automatic clear_state();
        stall_v = 1'b0; flush_v = 1'b0;
        grant_limit = 0; grants = 0; gnt_delay = 0; req_age = 0; rsp_lat = 1; pops = 0;
        first_grant_cyc = -1; first_valid_cyc = -1; last_pop_cyc = -1;
        ready_cnt = 0; req_cnt = 0; last_pop_pc = 32'd0;
    endtask

    // One clock cycle: called just after a rising edge, returns just after the next.
    task automatic step();
        logic [63:0] e;
        pc_i         = next_pc;
        pc_i_valid   = (grants < grant_limit);
        stall_i_EXEC = stall_v;
        flush_i      = flush_v;
        if (rsp_addr_q.size() > 0 && rsp_due_q[0] <= cyc) begin
            data_rvalid_i = 1'b1;
            data_rdata_i  = ~rsp_addr_q[0];
            void'(rsp_addr_q.pop_front());
            void'(rsp_due_q.pop_front());
        end else begin
            data_rvalid_i = 1'b0;
            data_rdata_i  = 32'd0;
        end
        if (flush_v) exp_q.delete();
        #1;
        data_gnt_i = data_req_o && (req_age >= gnt_delay);
        @(negedge clk);
        total++;
        if (pc_ready_o !== data_gnt_i)
            begin bad++; $display("FAIL pc_ready cyc=%0d: got %b want %b", cyc, pc_ready_o, data_gnt_i); end
        if (data_req_o) begin
            req_cnt++;
            total++;
            if (data_addr_o !== next_pc)
                begin bad++; $display("FAIL req_addr cyc=%0d: got %h want %h", cyc, data_addr_o, next_pc); end
        end
        if (pc_ready_o) ready_cnt++;
        if (data_req_o && data_gnt_i) begin
            rsp_addr_q.push_back(next_pc);
            rsp_due_q.push_back(cyc + rsp_lat);
            exp_q.push_back({next_pc, ~next_pc});
            if (first_grant_cyc < 0) first_grant_cyc = cyc;
            grants++;
            next_pc = next_pc + 32'd4;
            req_age = 0;
        end else if (data_req_o) begin
            req_age++;
        end else begin
            req_age = 0;
        end
        if (instr_valid_o && !stall_v && !flush_v) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            last_pop_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++; $display("FAIL unexpected_word cyc=%0d: got pc=%h data=%h want none", cyc, instr_pc_o, instruction_o);
            end else begin
                e = exp_q.pop_front();
                if ({instr_pc_o, instruction_o} !== e)
                    begin bad++; $display("FAIL word cyc=%0d: got pc=%h data=%h want %h", cyc, instr_pc_o, instruction_o, e); end
            end
            last_pop_pc = instr_pc_o;
            pops++;
        end
        if (!instr_valid_o) begin
            total++;
            if (instruction_o !== NOP)
                begin bad++; $display("FAIL idle_nop cyc=%0d: got %h want %h", cyc, instruction_o, NOP); end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid_o); end
        total++; if (instruction_o !== NOP) begin bad++; $display("FAIL rst_instr: got %h want %h", instruction_o, NOP); end
        total++; if (data_req_o !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", data_req_o); end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (reset_able !== 1'b1) begin bad++; $display("FAIL rst_able: got %b want 1", reset_able); end
        total++; if ({data_we_o, data_be_o, data_wdata_o} !== {1'b0, 4'b1111, 32'd0})
            begin bad++; $display("FAIL rst_consts: got we=%b be=%h wd=%h want 0 f 0", data_we_o, data_be_o, data_wdata_o); end
    endtask

    task automatic test_streaming();
        clear_state();
        next_pc = 32'h0; grant_limit = 3;
        for (int i = 0; i < 12; i++) step();
        total++; if (grants != 3) begin bad++; $display("FAIL stream_grants: got %0d want 3", grants); end
        total++; if (pops != 3) begin bad++; $display("FAIL stream_pops: got %0d want 3", pops); end
        total++; if (first_valid_cyc - first_grant_cyc != 2)
            begin bad++; $display("FAIL stream_latency: got %0d want 2", first_valid_cyc - first_grant_cyc); end
        total++; if (last_pop_cyc - first_valid_cyc != 2)
            begin bad++; $display("FAIL stream_rate: got %0d want 2", last_pop_cyc - first_valid_cyc); end
        total++; if (reset_able !== 1'b1) begin bad++; $display("FAIL stream_idle: got %b want 1", reset_able); end
    endtask

    task automatic test_backpressure();
        clear_state();
        next_pc = 32'h40; grant_limit = 100; stall_v = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (instr_valid_o) begin
                total++;
                if (instr_pc_o !== 32'h40) begin bad++; $display("FAIL bp_head: got %h want 00000040", instr_pc_o); end
            end
        end
        total++; if (grants != 4) begin bad++; $display("FAIL bp_grants: got %0d want 4", grants); end
        total++; if (data_req_o !== 1'b0) begin bad++; $display("FAIL bp_req_off: got %b want 0", data_req_o); end
        total++; if (instr_valid_o !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", instr_valid_o); end
        grant_limit = grants; stall_v = 1'b0;
        for (int i = 0; i < 8; i++) step();
        total++; if (pops != 4) begin bad++; $display("FAIL bp_pops: got %0d want 4", pops); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_left: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_flush_outstanding();
        int fc;
        clear_state();
        rsp_lat = 3; next_pc = 32'h200; grant_limit = 2;
        step(); step();
        total++; if (grants != 2) begin bad++; $display("FAIL fl_setup: got %0d want 2", grants); end
        grants = 0; grant_limit = 1; first_grant_cyc = -1; next_pc = 32'h100;
        fc = cyc; flush_v = 1'b1;
        step();
        flush_v = 1'b0;
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL fl_valid: got %b want 0", instr_valid_o); end
        for (int i = 0; i < 10; i++) step();
        total++; if (first_grant_cyc != fc + 2)
            begin bad++; $display("FAIL fl_resume: got %0d want %0d", first_grant_cyc, fc + 2); end
        total++; if (pops != 1 || last_pop_pc !== 32'h100)
            begin bad++; $display("FAIL fl_first: got pops=%0d pc=%h want 1 00000100", pops, last_pop_pc); end
    endtask

    task automatic test_flush_rvalid();
        int fc;
        clear_state();
        rsp_lat = 2; next_pc = 32'h300; grant_limit = 2;
        step(); step();
        grants = 0; grant_limit = 1; first_grant_cyc = -1; next_pc = 32'h380;
        fc = cyc; flush_v = 1'b1;
        step();
        flush_v = 1'b0;
        for (int i = 0; i < 8; i++) step();
        total++; if (first_grant_cyc != fc + 1)
            begin bad++; $display("FAIL flr_resume: got %0d want %0d", first_grant_cyc, fc + 1); end
        total++; if (pops != 1 || last_pop_pc !== 32'h380)
            begin bad++; $display("FAIL flr_first: got pops=%0d pc=%h want 1 00000380", pops, last_pop_pc); end
    endtask

    task automatic test_gnt_delay();
        int sc;
        clear_state();
        gnt_delay = 3; next_pc = 32'h500; grant_limit = 1;
        sc = cyc;
        for (int i = 0; i < 8; i++) step();
        total++; if (req_cnt != 4) begin bad++; $display("FAIL gd_req_cycles: got %0d want 4", req_cnt); end
        total++; if (ready_cnt != 1) begin bad++; $display("FAIL gd_ready_pulses: got %0d want 1", ready_cnt); end
        total++; if (first_grant_cyc != sc + 3)
            begin bad++; $display("FAIL gd_grant_cyc: got %0d want %0d", first_grant_cyc, sc + 3); end
        total++; if (pops != 1) begin bad++; $display("FAIL gd_pops: got %0d want 1", pops); end
    endtask

    task automatic test_reset_mid();
        clear_state();
        next_pc = 32'h600; grant_limit = 100; stall_v = 1'b1;
        for (int i = 0; i < 4; i++) step();
        #1;
        reset_n = 1'b0;
        #1;
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL mr_valid: got %b want 0", instr_valid_o); end
        total++; if (instruction_o !== NOP || instr_pc_o !== 32'd0)
            begin bad++; $display("FAIL mr_instr: got %h/%h want %h/0", instruction_o, instr_pc_o, NOP); end
        total++; if (data_req_o !== 1'b0) begin bad++; $display("FAIL mr_req: got %b want 0", data_req_o); end
        rsp_addr_q.delete(); rsp_due_q.delete(); exp_q.delete();
        pc_i_valid = 1'b0; stall_i_EXEC = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (reset_able !== 1'b1) begin bad++; $display("FAIL mr_able: got %b want 1", reset_able); end
        data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        data_rvalid_i = 1'b0;
        @(posedge clk);
        #1;
        total++; if (instr_valid_o !== 1'b0) begin bad++; $display("FAIL mr_late_rvalid: got %b want 0", instr_valid_o); end
        total++; if (reset_able !== 1'b1) begin bad++; $display("FAIL mr_able_late: got %b want 1", reset_able); end
    endtask

    initial begin
        clear_state();
        next_pc = 32'd0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_outstanding();
        test_flush_rvalid();
        test_gnt_delay();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
